// File: rtl/sb_rdi_pl_cfg_tx.sv
// Sideband RDI transmit stage: serializes 64-bit header (+ optional 64-bit payload)
// onto the NC-bit pl_cfg bus with one vld rising edge (credit consume) per message.
module sb_rdi_pl_cfg_tx #(
  parameter int NC = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_msg_valid,
  input  logic [63:0]   i_msg_hdr,
  input  logic          i_msg_has_data,
  input  logic [63:0]   i_msg_data,
  output logic          o_msg_ready,
  input  logic          i_adapter_is_full,
  output logic [NC-1:0] o_pl_cfg,
  output logic          o_pl_cfg_vld,
  output logic          o_rising_edge_pl_cfg_vld
);

  localparam int B  = 64 / NC;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_nxt;
  logic [63:0]   hdr_q;
  logic [63:0]   data_q;
  logic          has_data_q;
  logic          accept;

  function automatic logic [NC-1:0] beat_of(input logic [63:0] word, input logic [CW-1:0] k);
    logic [63:0] shifted;
    shifted = word >> (int'(k) * NC);
    return shifted[NC-1:0];
  endfunction

  // Credits are only checked while idle; an accepted message always runs to completion.
  assign o_msg_ready = (state == IDLE) && !i_adapter_is_full;
  assign accept      = i_msg_valid && o_msg_ready;
  assign beat_nxt    = beat_cnt + CW'(1);

  // Outputs are loaded one beat ahead so beat k is on the bus while beat_cnt == k.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                    <= IDLE;
      beat_cnt                 <= '0;
      hdr_q                    <= '0;
      data_q                   <= '0;
      has_data_q               <= 1'b0;
      o_pl_cfg                 <= '0;
      o_pl_cfg_vld             <= 1'b0;
      o_rising_edge_pl_cfg_vld <= 1'b0;
    end else begin
      o_rising_edge_pl_cfg_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hdr_q                    <= i_msg_hdr;
            data_q                   <= i_msg_data;
            has_data_q               <= i_msg_has_data;
            beat_cnt                 <= '0;
            state                    <= HDR;
            o_pl_cfg                 <= i_msg_hdr[NC-1:0];
            o_pl_cfg_vld             <= 1'b1;
            o_rising_edge_pl_cfg_vld <= 1'b1;
          end
        end
        HDR: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            if (has_data_q) begin
              state    <= DATA;
              o_pl_cfg <= data_q[NC-1:0];
            end else begin
              state        <= IDLE;
              o_pl_cfg     <= '0;
              o_pl_cfg_vld <= 1'b0;
            end
          end else begin
            beat_cnt <= beat_nxt;
            o_pl_cfg <= beat_of(hdr_q, beat_nxt);
          end
        end
        DATA: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt     <= '0;
            state        <= IDLE;
            o_pl_cfg     <= '0;
            o_pl_cfg_vld <= 1'b0;
          end else begin
            beat_cnt <= beat_nxt;
            o_pl_cfg <= beat_of(data_q, beat_nxt);
          end
        end
        default: begin
          state        <= IDLE;
          beat_cnt     <= '0;
          o_pl_cfg     <= '0;
          o_pl_cfg_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_rdi_pl_cfg_tx.sv
// Directed bench for sb_rdi_pl_cfg_tx: three instances (NC = 8, 16, 32) plus a
// credit counter model feeding the NC=32 instance's adapter-full input.
module tb_sb_rdi_pl_cfg_tx;

  logic clk;
  logic rst_n;

  logic        valid_8, has_data_8, ready_8, full_8, vld_8, pulse_8;
  logic [63:0] hdr_8, data_8;
  logic [7:0]  pl_cfg_8;

  logic        valid_16, has_data_16, ready_16, full_16, vld_16, pulse_16;
  logic [63:0] hdr_16, data_16;
  logic [15:0] pl_cfg_16;

  logic        valid_32, has_data_32, ready_32, full_32, vld_32, pulse_32;
  logic [63:0] hdr_32, data_32;
  logic [31:0] pl_cfg_32;

  logic use_model, crd_load, crd, full_force_32;
  int   credits;

  int cmp_count;
  int err_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_rdi_pl_cfg_tx #(.NC(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_msg_valid(valid_8), .i_msg_hdr(hdr_8),
    .i_msg_has_data(has_data_8), .i_msg_data(data_8), .o_msg_ready(ready_8),
    .i_adapter_is_full(full_8), .o_pl_cfg(pl_cfg_8), .o_pl_cfg_vld(vld_8),
    .o_rising_edge_pl_cfg_vld(pulse_8)
  );

  sb_rdi_pl_cfg_tx #(.NC(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_msg_valid(valid_16), .i_msg_hdr(hdr_16),
    .i_msg_has_data(has_data_16), .i_msg_data(data_16), .o_msg_ready(ready_16),
    .i_adapter_is_full(full_16), .o_pl_cfg(pl_cfg_16), .o_pl_cfg_vld(vld_16),
    .o_rising_edge_pl_cfg_vld(pulse_16)
  );

  sb_rdi_pl_cfg_tx #(.NC(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_msg_valid(valid_32), .i_msg_hdr(hdr_32),
    .i_msg_has_data(has_data_32), .i_msg_data(data_32), .o_msg_ready(ready_32),
    .i_adapter_is_full(full_32), .o_pl_cfg(pl_cfg_32), .o_pl_cfg_vld(vld_32),
    .o_rising_edge_pl_cfg_vld(pulse_32)
  );

  // Credit counter model: each vld rising-edge pulse consumes, each crd pulse returns one.
  always @(posedge clk) begin
    if (crd_load) credits <= 32;
    else          credits <= credits - int'(pulse_32) + int'(crd);
  end
  assign full_32 = use_model ? (credits == 0) : full_force_32;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    cmp_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [7:0]  beats8 [16];
    logic [7:0]  exp5 [8];
    logic [15:0] exp3 [12];
    logic [15:0] got3 [12];
    logic [63:0] msgs3 [3];
    logic [14:0] vld_vec, pulse_vec;
    int nbeat, idx, acc, cyc, vld_hi, pulses, got;
    logic acc_flag;

    cmp_count = 0;
    err_count = 0;
    rst_n = 1'b0;
    valid_8 = 0; has_data_8 = 0; hdr_8 = '0; data_8 = '0; full_8 = 0;
    valid_16 = 0; has_data_16 = 0; hdr_16 = '0; data_16 = '0; full_16 = 0;
    valid_32 = 0; has_data_32 = 0; hdr_32 = '0; data_32 = '0; full_force_32 = 0;
    use_model = 0; crd_load = 1; crd = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_vld", vld_32, 1'b0);
    checkOutput("rst_pl_cfg", pl_cfg_32, 32'h0);
    checkOutput("rst_pulse", pulse_32, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", ready_32, 1'b1);
    checkOutput("rst_vld_after", vld_16, 1'b0);

    // Header-only message on NC=32.
    $display("[TB] header-only NC=32");
    hdr_32 = 64'h1122_3344_5566_7788; has_data_32 = 0; valid_32 = 1;
    #1 checkOutput("t1_ready_t", ready_32, 1'b1);
    @(negedge clk);
    valid_32 = 0;
    checkOutput("t1_beat0", pl_cfg_32, 32'h5566_7788);
    checkOutput("t1_vld0", vld_32, 1'b1);
    checkOutput("t1_pulse0", pulse_32, 1'b1);
    checkOutput("t1_ready_busy", ready_32, 1'b0);
    @(negedge clk);
    checkOutput("t1_beat1", pl_cfg_32, 32'h1122_3344);
    checkOutput("t1_vld1", vld_32, 1'b1);
    checkOutput("t1_pulse1", pulse_32, 1'b0);
    @(negedge clk);
    checkOutput("t1_vld_end", vld_32, 1'b0);
    checkOutput("t1_pl_end", pl_cfg_32, 32'h0);
    checkOutput("t1_ready_back", ready_32, 1'b1);

    // Header plus payload on NC=8.
    $display("[TB] header+payload NC=8");
    hdr_8 = 64'h0807_0605_0403_0201; data_8 = 64'hA5A5_0000_FFFF_0001;
    has_data_8 = 1; valid_8 = 1;
    vld_hi = 0; pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      valid_8 = 0;
      beats8[k] = pl_cfg_8;
      if (vld_8) vld_hi++;
      if (pulse_8) pulses++;
    end
    checkOutput("t2_vld_cycles", vld_hi, 16);
    checkOutput("t2_pulses", pulses, 1);
    checkOutput("t2_beat0", beats8[0], 8'h01);
    checkOutput("t2_beat7", beats8[7], 8'h08);
    checkOutput("t2_beat8", beats8[8], 8'h01);
    checkOutput("t2_beat10", beats8[10], 8'hFF);
    checkOutput("t2_beat13", beats8[13], 8'h00);
    checkOutput("t2_beat15", beats8[15], 8'hA5);
    @(negedge clk);
    checkOutput("t2_vld_end", vld_8, 1'b0);
    checkOutput("t2_ready_end", ready_8, 1'b1);

    // Back-to-back header-only messages on NC=16 with valid held high.
    $display("[TB] back-to-back NC=16");
    msgs3[0] = 64'h0001_0002_0003_0004;
    msgs3[1] = 64'h1111_2222_3333_4444;
    msgs3[2] = 64'hDEAD_BEEF_CAFE_F00D;
    exp3 = '{16'h0004, 16'h0003, 16'h0002, 16'h0001,
             16'h4444, 16'h3333, 16'h2222, 16'h1111,
             16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};
    has_data_16 = 0; hdr_16 = msgs3[0]; valid_16 = 1;
    #1 acc_flag = ready_16 & valid_16;
    idx = 0; nbeat = 0; vld_vec = '0; pulse_vec = '0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (acc_flag) begin
        idx++;
        if (idx < 3) hdr_16 = msgs3[idx];
        else         valid_16 = 0;
      end
      vld_vec   = {vld_vec[13:0], vld_16};
      pulse_vec = {pulse_vec[13:0], pulse_16};
      if (vld_16 && nbeat < 12) begin
        got3[nbeat] = pl_cfg_16;
        nbeat++;
      end
      acc_flag = ready_16 & valid_16;
    end
    checkOutput("t3_vld_pattern", vld_vec, 15'b111101111011110);
    checkOutput("t3_pulse_pattern", pulse_vec, 15'b100001000010000);
    checkOutput("t3_beat_count", nbeat, 12);
    for (int j = 0; j < 12; j++) checkOutput($sformatf("t3_beat%0d", j), got3[j], exp3[j]);
    checkOutput("t3_ready_end", ready_16, 1'b1);

    // Credit exhaustion on NC=32 driven by the credit counter model.
    $display("[TB] credit exhaustion NC=32");
    use_model = 1; crd_load = 0; has_data_32 = 0;
    hdr_32 = 64'hC0DE_0000_0000_00AA; valid_32 = 1;
    #1;
    acc = 0; cyc = 0;
    while (acc < 32 && cyc < 200) begin
      if (ready_32) acc++;
      if (acc < 32) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("t4_accepts", acc, 32);
    @(negedge clk);
    hdr_32 = 64'h3333_4444_5555_6666;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_ready_full", ready_32, 1'b0);
    checkOutput("t4_credits", credits, 0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (pulse_32 || vld_32 || ready_32) pulses++;
    end
    checkOutput("t4_held", pulses, 0);
    crd = 1;
    @(negedge clk);
    crd = 0;
    got = 0;
    for (int i = 0; i < 2; i++) begin
      if (ready_32) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t4_reenable", got, 1);
    @(negedge clk);
    valid_32 = 0;
    checkOutput("t4_msg33_pulse", pulse_32, 1'b1);
    checkOutput("t4_msg33_beat0", pl_cfg_32, 32'h5555_6666);
    @(negedge clk);
    checkOutput("t4_msg33_beat1", pl_cfg_32, 32'h3333_4444);
    use_model = 0;

    // Full asserted during HDR beat 1 on NC=8: message still completes.
    $display("[TB] full mid-message NC=8");
    exp5 = '{8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    hdr_8 = 64'hF0E1_D2C3_B4A5_9687; has_data_8 = 0; valid_8 = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      valid_8 = 0;
      if (k == 1) full_8 = 1;
      checkOutput($sformatf("t5_beat%0d", k), {vld_8, pl_cfg_8}, {1'b1, exp5[k]});
    end
    @(negedge clk);
    checkOutput("t5_vld_end", vld_8, 1'b0);
    checkOutput("t5_ready_full", ready_8, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t5_ready_still", ready_8, 1'b0);
    full_8 = 0;
    #1 checkOutput("t5_ready_free", ready_8, 1'b1);

    // Reset during DATA beat 2 on NC=16.
    $display("[TB] reset mid-message NC=16");
    @(negedge clk);
    hdr_16 = 64'h0123_4567_89AB_CDEF; data_16 = 64'h1357_9BDF_2468_ACE0;
    has_data_16 = 1; valid_16 = 1;
    @(negedge clk);
    valid_16 = 0;
    repeat (6) @(negedge clk);
    checkOutput("t6_data_beat2", {vld_16, pl_cfg_16}, {1'b1, 16'h9BDF});
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vld", vld_16, 1'b0);
    checkOutput("t6_rst_pl", pl_cfg_16, 16'h0);
    checkOutput("t6_rst_pulse", pulse_16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hdr_16 = 64'hAAAA_BBBB_CCCC_DDDD; has_data_16 = 0; valid_16 = 1;
    #1 checkOutput("t6_ready_idle", ready_16, 1'b1);
    @(negedge clk);
    valid_16 = 0;
    checkOutput("t6_new_pulse", pulse_16, 1'b1);
    checkOutput("t6_new_beat0", {vld_16, pl_cfg_16}, {1'b1, 16'hDDDD});
    @(negedge clk);
    checkOutput("t6_new_beat1", pl_cfg_16, 16'hCCCC);
    repeat (3) @(negedge clk);
    checkOutput("t6_new_end", vld_16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/sb_rdi_pl_cfg_tx.md
# sb_rdi_pl_cfg_tx

Sideband RDI transmit stage toward the Adapter. It accepts 64-bit sideband messages (header plus optional 64-bit data payload) from the sideband message source. It serializes each message onto the `o_pl_cfg` bus as NC-bit beats, framed by `o_pl_cfg_vld`. It emits one `o_rising_edge_pl_cfg_vld` pulse per message, which feeds the credit counter's consume input. It stalls new messages while the credit counter reports `i_adapter_is_full`.

## Interface
- `NC`, default 32: `pl_cfg` width in bits. Legal values are 8, 16, 32. Beats per 64-bit word: B = 64/NC.
- `i_clk`  in  1: sideband clock. All logic is on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_msg_valid`  in  1: source has a message ready.
- `i_msg_hdr`  in  64: message header.
- `i_msg_has_data`  in  1: message carries a 64-bit payload.
- `i_msg_data`  in  64: payload; ignored when `i_msg_has_data`=0.
- `o_msg_ready`  out  1: block accepts a message this cycle.
- `i_adapter_is_full`  in  1: Adapter credits exhausted (from the credit counter).
- `o_pl_cfg`  out  NC: serialized beat to the Adapter.
- `o_pl_cfg_vld`  out  1: `o_pl_cfg` holds a valid beat.
- `o_rising_edge_pl_cfg_vld`  out  1: one-cycle pulse on the first beat of each message (credit consume).

## Operation
- States:
  - IDLE: `o_pl_cfg_vld`=0.
  - HDR: sends header beats.
  - DATA: sends payload beats.
- `o_msg_ready` = (state==IDLE) & ~`i_adapter_is_full`. This is combinational and registered-state based.
- Accept = `i_msg_valid` & `o_msg_ready`. On accept:
  - Latch `i_msg_hdr`, `i_msg_data` and `i_msg_has_data` into internal registers.
  - Load beat counter = 0.
  - Go to HDR.
- HDR: drive beat k = hdr[k*NC +: NC]. Beats go LSB first, k = 0..B-1.
  - After beat B-1, go to DATA if has_data, else IDLE.
- DATA: same ordering over the payload. After beat B-1, go to IDLE.
- Beat counter width is clog2(B), minimum 1 bit. It resets to 0 on each state entry. There is no wrap within a word.
- `o_pl_cfg_vld` stays continuously 1 from the first header beat through the last beat of the message. It is 0 in IDLE.
- Every message is therefore followed by at least one vld-low cycle. This guarantees exactly one rising edge per message, which means exactly one credit per message.
- `o_rising_edge_pl_cfg_vld` = 1 only in the cycle of header beat 0. It is registered and aligned with `o_pl_cfg_vld`.
- Once accepted, a message completes all beats regardless of `i_adapter_is_full`, because its credit is already consumed.
- `i_adapter_is_full` is sampled only in IDLE, through `o_msg_ready`.
- `o_pl_cfg` = 0 whenever `o_pl_cfg_vld`=0.
- Latched message registers are not updated outside an accept.

## Timing
- Reset (async assert):
  - state=IDLE, beat counter=0.
  - `o_pl_cfg`=0, `o_pl_cfg_vld`=0, `o_rising_edge_pl_cfg_vld`=0.
  - Latched message registers = 0.
  - `o_msg_ready` follows ~`i_adapter_is_full` once in IDLE.
- Reset deassertion is synchronized externally; the block uses no reset synchronizer.
- Accept in cycle t:
  - Header beat 0 and the pulse appear in t+1.
  - Last header beat in t+B.
  - Payload, if present, in t+B+1 .. t+2B.
- Message length: B beats header-only, 2B beats with payload.
- Back-to-back: the last beat is in cycle u, IDLE (vld=0) is in u+1, and the earliest next accept is u+1. The next beat 0 is then in u+2.
- Credit interplay:
  - The pulse in t+1 decrements the counter at the end of t+1, so updated `i_adapter_is_full` is valid from t+2.
  - The next IDLE is at or after t+B+1 ≥ t+2, so no credit over-consumption is possible.
- Reset mid-message: the in-flight message is dropped and vld falls asynchronously. The source is responsible for retransmit policy.
- `i_msg_valid` while not in IDLE: it is ignored (ready=0), and the source must hold its message.

## Test plan
- Single header-only message, NC=32, hdr=64'h1122_3344_5566_7788. Required: beats 32'h5566_7788 then 32'h1122_3344 in t+1, t+2; vld high 2 cycles; pulse only in t+1; ready returns in t+3.
- Header plus payload, NC=8, data=64'hA5A5_0000_FFFF_0001. Required: vld high for 16 consecutive cycles; beat 8 = 8'h01, beat 15 = 8'hA5; exactly one pulse.
- Back-to-back: 3 header-only messages with `i_msg_valid` held high, NC=16. Required: each message is 4 beats; exactly one vld-low cycle between messages; 3 pulses total.
- Credit exhaustion with a credit counter model starting at 32: send 32 header-only messages and no credit returns. Required: after the 32nd, `o_msg_ready`=0 and the 33rd is held. A single `lp_cfg_crd` pulse must re-enable ready within 2 cycles, and the 33rd message is then sent.
- Full asserted mid-message, in HDR beat 1. Required: all remaining beats are still sent and ready stays 0 afterward.
- Reset asserted in DATA beat 2. Required: `o_pl_cfg_vld`, `o_pl_cfg` and the pulse go to 0 immediately; state is IDLE after release; the next message starts cleanly at beat 0.
